// File: rtl/shift_pkg.sv
// Shared types and widths for the shift operand feeder and its request FIFO.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] A;
    logic [CTRL_W-1:0] B;
  } shift_req_t;

  // B is opaque control; requests are built without interpreting it.
  function automatic shift_req_t make_req(input logic [DATA_W-1:0] a, input logic [CTRL_W-1:0] b);
    shift_req_t r;
    r.A = a;
    r.B = b;
    return r;
  endfunction

endpackage

// File: rtl/shift_operand_feeder_if.sv
// Request and result handshake bundle between the feeder and its producer/consumer.
interface shift_operand_feeder_if;
  import shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_A;
  logic [CTRL_W-1:0] in_B;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_C;
  logic              out_carry;
  logic [DATA_W-1:0] out_A;
  logic [CTRL_W-1:0] out_B;

  modport slave (
    input  in_valid, in_A, in_B, out_ready,
    output in_ready, out_valid, out_C, out_carry, out_A, out_B
  );

  modport master (
    output in_valid, in_A, in_B, out_ready,
    input  in_ready, out_valid, out_C, out_carry, out_A, out_B
  );

endinterface

// File: rtl/shift_req_fifo.sv
// Synchronous request FIFO with a register-backed head, occupancy count and
// same-cycle push/pop.
module shift_req_fifo
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  shift_req_t           wdata,
  output shift_req_t           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);

  shift_req_t         mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        level_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (push && (level_r != (AW+1)'(DEPTH))) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if (pop && (level_r != '0)) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
  end

  // Storage write port and pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == (AW+1)'(DEPTH));
  assign empty = (level_r == '0);

endmodule

// File: rtl/shift_operand_feeder.sv
// Feeds queued operands to a combinational shifter, holds them for a settle
// window, then presents the captured result with the operands echoed.
module shift_operand_feeder
  import shift_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_operand_feeder_if.slave  bus,
  output logic [DATA_W-1:0]      A,
  output logic [CTRL_W-1:0]      B,
  input  logic [DATA_W-1:0]      C,
  input  logic                   carry,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  feeder_state_t     state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] a_r;
  logic [CTRL_W-1:0] b_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_c_r;
  logic              out_carry_r;
  logic [DATA_W-1:0] out_a_r;
  logic [CTRL_W-1:0] out_b_r;

  shift_req_t        head_s;
  shift_req_t        wdata_s;
  logic              full_s;
  logic              empty_s;
  logic              in_ready_s;
  logic              push_s;
  logic              pop_s;

  // Ready drops during reset so nothing is queued while the FIFO is flushed.
  always_comb begin
    in_ready_s = 1'b0;
    push_s     = 1'b0;
    if (!rst && !full_s) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    push_s = bus.in_valid && in_ready_s;
  end

  // The head is popped when starting from IDLE or when a held result is taken.
  always_comb begin
    pop_s = 1'b0;
    if (rst || empty_s) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    pop_s = 1'b1;
        HOLD:    pop_s = bus.out_ready;
        default: pop_s = 1'b0;
      endcase
    end
  end

  assign wdata_s = make_req(bus.in_A, bus.in_B);

  shift_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .head  (head_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  // Sequencer: drive operands, count the settle window, capture, hold for consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      out_valid_r <= 1'b0;
      out_c_r     <= '0;
      out_carry_r <= 1'b0;
      out_a_r     <= '0;
      out_b_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            a_r     <= head_s.A;
            b_r     <= head_s.B;
            cnt_r   <= '0;
            state_r <= DRIVE;
          end
        end
        DRIVE: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(SETTLE - 1)) begin
            out_c_r     <= C;
            out_carry_r <= carry;
            out_a_r     <= a_r;
            out_b_r     <= b_r;
            out_valid_r <= 1'b1;
            state_r     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (!empty_s) begin
              // Back-to-back: next operands go out on the same edge the result leaves.
              a_r     <= head_s.A;
              b_r     <= head_s.B;
              cnt_r   <= '0;
              state_r <= DRIVE;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign A             = a_r;
  assign B             = b_r;
  assign busy          = (state_r != IDLE) || !empty_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_C     = out_c_r;
  assign bus.out_carry = out_carry_r;
  assign bus.out_A     = out_a_r;
  assign bus.out_B     = out_b_r;

endmodule

// File: tb/tb_shift_operand_feeder.sv
// Scoreboard bench: two feeders (SETTLE=1 and SETTLE=3) driving a stub shifter.
module tb_shift_operand_feeder;

  typedef struct packed {
    logic [31:0] c;
    logic        cy;
    logic [31:0] a;
    logic [6:0]  b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_operand_feeder_if f1 ();
  shift_operand_feeder_if f3 ();

  logic [31:0] a1, c1, a3, c3;
  logic [6:0]  b1, b3;
  logic        cy1, cy3, busy1, busy3;
  logic [2:0]  lvl1, lvl3;

  assign c1  = a1 + {25'd0, b1};
  assign cy1 = a1[31];
  assign c3  = a3 + {25'd0, b3};
  assign cy3 = a3[31];

  shift_operand_feeder #(.DEPTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(f1), .A(a1), .B(b1), .C(c1), .carry(cy1),
    .busy(busy1), .level(lvl1));

  shift_operand_feeder #(.DEPTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .bus(f3), .A(a3), .B(b3), .C(c3), .carry(cy3),
    .busy(busy3), .level(lvl3));

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_hs = 0;
  bit   have_last = 1'b0;
  bit   gap_en = 1'b0;
  exp_t q1[$];
  exp_t q3[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the SETTLE=1 feeder: result order, content and spacing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && f1.out_valid) begin
      if (q1.size() == 0) begin
        check("stale1", f1.out_valid, 1'b0);
      end else if (f1.out_ready) begin
        e = q1.pop_front();
        check("res1_C", f1.out_C, e.c);
        check("res1_carry", f1.out_carry, e.cy);
        check("res1_A", f1.out_A, e.a);
        check("res1_B", f1.out_B, e.b);
        if (gap_en && have_last) check("gap1", cyc - last_hs, 2);
        last_hs   = cyc;
        have_last = 1'b1;
      end
    end
  end

  // Monitor for the SETTLE=3 feeder.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && f3.out_valid) begin
      if (q3.size() == 0) begin
        check("stale3", f3.out_valid, 1'b0);
      end else if (f3.out_ready) begin
        e = q3.pop_front();
        check("res3_C", f3.out_C, e.c);
        check("res3_carry", f3.out_carry, e.cy);
        check("res3_A", f3.out_A, e.a);
        check("res3_B", f3.out_B, e.b);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push1(input logic [31:0] a, input logic [6:0] b, input logic [31:0] c,
                       input logic cy, output logic acc);
    f1.in_valid = 1'b1;
    f1.in_A     = a;
    f1.in_B     = b;
    @(negedge clk);
    acc = f1.in_ready;
    if (acc) q1.push_back('{c, cy, a, b});
    @(posedge clk);
    #1;
    if (acc) f1.in_valid = 1'b0;
  endtask

  task automatic drain1();
    for (int i = 0; i < 60 && q1.size() != 0; i++) @(posedge clk);
    #1;
    check("drain1", q1.size(), 0);
  endtask

  logic [31:0] va [6];
  logic [6:0]  vb [6];
  logic [31:0] vc [6];
  logic        vcy[6];
  logic        acc;
  logic        accs[6];

  initial begin
    va[0] = 32'h0000_1000; vb[0] = 7'h01; vc[0] = 32'h0000_1001; vcy[0] = 1'b0;
    va[1] = 32'hFFFF_FFF0; vb[1] = 7'h10; vc[1] = 32'h0000_0000; vcy[1] = 1'b1;
    va[2] = 32'h1234_5678; vb[2] = 7'h08; vc[2] = 32'h1234_5680; vcy[2] = 1'b0;
    va[3] = 32'h8000_0000; vb[3] = 7'h7F; vc[3] = 32'h8000_007F; vcy[3] = 1'b1;
    va[4] = 32'h7FFF_FFFF; vb[4] = 7'h01; vc[4] = 32'h8000_0000; vcy[4] = 1'b0;
    va[5] = 32'h0000_0055; vb[5] = 7'h2A; vc[5] = 32'h0000_007F; vcy[5] = 1'b0;

    f1.in_valid = 1'b0; f1.in_A = 32'd0; f1.in_B = 7'd0; f1.out_ready = 1'b1;
    f3.in_valid = 1'b0; f3.in_A = 32'd0; f3.in_B = 7'd0; f3.out_ready = 1'b1;

    // Reset for two cycles.
    @(posedge clk); #1;
    check("rst_in_ready1", f1.in_ready, 1'b0);
    check("rst_in_ready3", f3.in_ready, 1'b0);
    @(posedge clk); #1;
    check("rst2_in_ready1", f1.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", f1.out_valid, 1'b0);
    check("post_rst_A", a1, 32'd0);
    check("post_rst_B", b1, 7'd0);
    check("post_rst_out_C", f1.out_C, 32'd0);
    check("post_rst_level", lvl1, 3'd0);
    check("post_rst_busy", busy1, 1'b0);
    check("post_rst_in_ready", f1.in_ready, 1'b1);

    // SETTLE=3 latency: result visible exactly four edges after accept.
    f3.in_valid = 1'b1; f3.in_A = 32'h8000_0001; f3.in_B = 7'h7F;
    @(negedge clk);
    check("s5_accept", f3.in_ready, 1'b1);
    if (f3.in_ready) q3.push_back('{32'h8000_0080, 1'b1, 32'h8000_0001, 7'h7F});
    @(posedge clk); #1;
    f3.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        check("s5_early_valid", f3.out_valid, 1'b0);
      end else begin
        check("s5_valid", f3.out_valid, 1'b1);
        check("s5_out_C", f3.out_C, 32'h8000_0080);
        check("s5_carry", f3.out_carry, 1'b1);
      end
    end

    // SETTLE=1 single request.
    push1(32'h0000_00F0, 7'h04, 32'h0000_00F4, 1'b0, acc);
    check("s2_accept", acc, 1'b1);
    @(posedge clk); #1;
    check("s2_A", a1, 32'h0000_00F0);
    check("s2_B", b1, 7'h04);
    check("s2_early_valid", f1.out_valid, 1'b0);
    @(posedge clk); #1;
    check("s2_valid", f1.out_valid, 1'b1);
    check("s2_out_C", f1.out_C, 32'h0000_00F4);
    check("s2_carry", f1.out_carry, 1'b0);
    check("s2_out_A", f1.out_A, 32'h0000_00F0);
    check("s2_out_B", f1.out_B, 7'h04);
    repeat (3) @(posedge clk);
    #1;

    // Fill: one in flight plus four queued, sixth refused.
    f1.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push1(va[i], vb[i], vc[i], vcy[i], acc);
      accs[i] = acc;
    end
    for (int i = 0; i < 6; i++) check("s3_accept", accs[i], (i < 5) ? 1'b1 : 1'b0);
    check("s3_level", lvl1, 3'd4);
    check("s3_held_C", f1.out_C, 32'h0000_1001);
    repeat (3) @(posedge clk);
    #1;
    check("s3_still_C", f1.out_C, 32'h0000_1001);
    check("s3_still_valid", f1.out_valid, 1'b1);
    check("s3_full_ready", f1.in_ready, 1'b0);

    // Drain in order; the pending sixth request enters one cycle after the first pop.
    have_last = 1'b0;
    gap_en    = 1'b1;
    f1.out_ready = 1'b1;
    @(negedge clk);
    check("s4_ready_before_pop", f1.in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("s4_ready_after_pop", f1.in_ready, 1'b1);
    if (f1.in_ready) q1.push_back('{vc[5], vcy[5], va[5], vb[5]});
    @(posedge clk); #1;
    f1.in_valid = 1'b0;
    drain1();
    gap_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while holding a result with three queued behind it.
    f1.out_ready = 1'b0;
    push1(32'h0000_0001, 7'h01, 32'h0000_0002, 1'b0, acc);
    push1(32'h0000_0002, 7'h02, 32'h0000_0004, 1'b0, acc);
    push1(32'h0000_0003, 7'h03, 32'h0000_0006, 1'b0, acc);
    push1(32'h0000_0004, 7'h04, 32'h0000_0008, 1'b0, acc);
    check("s6_level", lvl1, 3'd3);
    check("s6_holding", f1.out_valid, 1'b1);
    check("s6_busy", busy1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("s6_rst_ready", f1.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete();
    q3.delete();
    #1;
    check("s6_out_valid", f1.out_valid, 1'b0);
    check("s6_level0", lvl1, 3'd0);
    check("s6_idle", busy1, 1'b0);
    check("s6_A", a1, 32'd0);
    check("s6_out_C", f1.out_C, 32'd0);
    check("s6_in_ready", f1.in_ready, 1'b1);
    f1.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push1(32'hABCD_0000, 7'h05, 32'hABCD_0005, 1'b1, acc);
    check("s6_post_accept", acc, 1'b1);
    drain1();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
